data_mem_responder: RTL

- Responder end of the MEM-stage load/store interface. The pipeline's MEM stage is the initiator; this block answers it.
- Accepts one read or write request at a time over a valid/ready handshake.
- Services it from internal word RAM after a fixed, parameterised latency. Returns read data with a single-cycle response strobe.
- Drives a stall line that freezes the pipeline while the request is in flight.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_ram.sv | 51 +++++
 rtl/data_mem_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_DEPTH  = 1024;
  localparam int LAT_CNT_W   = 4;

  // Counter preload for a given latency: the BUSY phase spans LATENCY-1 cycles.
  function automatic logic [LAT_CNT_W-1:0] lat_preload(input int unsigned lat);
    return LAT_CNT_W'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM: one read or one write per edge,
// registered read data that only changes on a read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read data next value: refresh on a read, otherwise hold the last load.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem_q[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage load/store handshake. Accepts one request
// at a time, services it from dmem_ram after LATENCY cycles and strobes
// rsp_valid for one cycle. The RESP state is the cycle whose closing edge
// performs the RAM access; the response registers present it on the next one.
// Optional build macro: DMEM_RANGE_CHECK_EN (flag addresses >= DEPTH).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t          state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [IDX_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;

  logic                 ready_s;
  logic                 accept_s;
  logic                 ram_en_s;
  logic [DATA_W-1:0]    ram_rdata_s;

`ifdef DMEM_RANGE_CHECK_EN
  logic oor_s;
  logic oor_q, oor_d;
  logic rsp_err_q, rsp_err_d;
  logic rzero_q, rzero_d;

  assign oor_s = (32'(req_addr) >= 32'(DEPTH));
`else
  if (ADDR_W > IDX_W) begin : g_addr_hi
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^req_addr[ADDR_W-1:IDX_W];
  end
`endif

  // Handshake: ready in IDLE and RESP, never while reset is asserted.
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else if ((state_q == IDLE) || (state_q == RESP)) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s  = ready_s && req_valid;
  assign req_ready = ready_s;
  assign stall     = (state_q == BUSY) || accept_s;

  // FSM state and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {LAT_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down through BUSY, RESP is always a single cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s) begin
          cnt_d = lat_preload(LATENCY);
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q <= LAT_CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {LAT_CNT_W{1'b0}};
      end
    endcase
  end

  // Request capture: latch the command only on the accepting edge.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef DMEM_RANGE_CHECK_EN
    oor_d   = oor_q;
`endif
    if (accept_s) begin
      we_d    = req_we;
      addr_d  = req_addr[IDX_W-1:0];
      wdata_d = req_wdata;
`ifdef DMEM_RANGE_CHECK_EN
      oor_d   = oor_s;
`endif
    end else begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef DMEM_RANGE_CHECK_EN
      oor_d   = oor_q;
`endif
    end
  end

  // Captured request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= {IDX_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
`ifdef DMEM_RANGE_CHECK_EN
      oor_q   <= 1'b0;
`endif
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef DMEM_RANGE_CHECK_EN
      oor_q   <= oor_d;
`endif
    end
  end

  // Outputs: RAM access at the end of RESP, response strobe on the following cycle.
  always_comb begin
    rsp_valid_d = (state_q == RESP);
`ifdef DMEM_RANGE_CHECK_EN
    ram_en_s    = (state_q == RESP) && !rst && !oor_q;
    rsp_err_d   = (state_q == RESP) && oor_q;
    if ((state_q == RESP) && !we_q) begin
      rzero_d = oor_q;
    end else begin
      rzero_d = rzero_q;
    end
`else
    ram_en_s    = (state_q == RESP) && !rst;
`endif
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      rsp_err_q   <= 1'b0;
      rzero_q     <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= rsp_valid_d;
`ifdef DMEM_RANGE_CHECK_EN
      rsp_err_q   <= rsp_err_d;
      rzero_q     <= rzero_d;
`endif
    end
  end

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en_s),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata_s)
  );

  assign rsp_valid = rsp_valid_q;
`ifdef DMEM_RANGE_CHECK_EN
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rzero_q ? {DATA_W{1'b0}} : ram_rdata_s;
`else
  assign rsp_err   = 1'b0;
  assign rsp_rdata = ram_rdata_s;
`endif

endmodule
